// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg
// Shared types and constants for the iterative multiply/divide unit.
//   MulDivOper    : operation select (MulU, MulS, DivU, DivS)
//   MulDivState   : controller state encoding
//   StrcInMulDiv  : control-side request bundle (start/oper/flush)
//   StrcOutMulDiv : control-side response bundle (busy/done/flags)
//   FLAG_*        : bit positions of N/V/Z/C, shared with the ALU flag slot
// Optional feature macro used by the files that import this package:
//   CPU_MULDIV_DIV_EN - when defined the divide datapath is built.
package mul_div_unit_pkg;

    localparam int CPU_WORD_WIDTH = 32;

    // Iteration counter must hold 0 .. WIDTH-1 with a spare bit.
    localparam int MD_CNT_W = $clog2(CPU_WORD_WIDTH) + 1;

    localparam int FLAG_N = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        MulU = 2'd0,
        MulS = 2'd1,
        DivU = 2'd2,
        DivS = 2'd3
    } MulDivOper;

    typedef enum logic [1:0] {
        MdIdle = 2'd0,
        MdRun  = 2'd1,
        MdFix  = 2'd2,
        MdDone = 2'd3
    } MulDivState;

    typedef struct packed {
        logic      start;
        MulDivOper oper;
        logic      flush;
    } StrcInMulDiv;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [3:0] flags;
    } StrcOutMulDiv;

    function automatic int md_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mul_div_step.sv
// mul_div_step
// Combinational single-iteration datapath of the multiply/divide unit.
// Multiply: shift-add on {hi, lo}, multiplier bits consumed from lo[0].
// Divide  : restoring shift-subtract; hi is the partial remainder, lo the
//           dividend shifting out at the top and quotient shifting in.
// Ports:
//   is_div  in  1      select divide step (present only with CPU_MULDIV_DIV_EN)
//   hi      in  WIDTH  product high half / partial remainder
//   lo      in  WIDTH  multiplier+product low half / dividend+quotient
//   opnd    in  WIDTH  multiplicand magnitude / divisor magnitude
//   hi_next out WIDTH  next hi
//   lo_next out WIDTH  next lo
// Macro: CPU_MULDIV_DIV_EN builds the divide path; otherwise multiply only.
module mul_div_step #(
    parameter int WIDTH = 32
) (
`ifdef CPU_MULDIV_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;

    // The carry out of the add becomes the new top bit after the right shift.
    always_comb begin
        sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_hi = sum[WIDTH:1];
        mul_lo = {sum[0], lo[WIDTH-1:1]};
    end

`ifdef CPU_MULDIV_DIV_EN
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;

    // The remainder stays below the divisor, so the shifted value fits in
    // WIDTH+1 bits and diff[WIDTH] is a clean borrow indicator.
    always_comb begin
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        if (!diff[WIDTH]) begin
            div_hi = diff[WIDTH-1:0];
            div_lo = {lo[WIDTH-2:0], 1'b1};
        end else begin
            div_hi = shifted[WIDTH-1:0];
            div_lo = {lo[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        hi_next = is_div ? div_hi : mul_hi;
        lo_next = is_div ? div_lo : mul_lo;
    end
`else
    always_comb begin
        hi_next = mul_hi;
        lo_next = mul_lo;
    end
`endif

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit
// Iterative multiply/divide unit, one bit per cycle, one operation in flight.
// Operands are reduced to magnitudes at start; signs are restored in FIX.
//
// state  | meaning
// -------+-------------------------------------------------------------
// MdIdle | waiting for start
// MdRun  | WIDTH shift-add / shift-subtract iterations
// MdFix  | sign correction, special cases, flag generation
// MdDone | one-cycle done pulse; start here chains the next operation
//
// Ports:
//   clk     in  1      clock, rising edge
//   rst_n   in  1      asynchronous active-low reset
//   start   in  1      request, sampled in IDLE/DONE
//   oper    in  2      MulU / MulS / DivU / DivS
//   a       in  WIDTH  multiplicand / dividend
//   b       in  WIDTH  multiplier / divisor
//   flush   in  1      abandon current operation (beats start)
//   busy    out 1      high in RUN and FIX
//   done    out 1      high in DONE
//   out_lo  out WIDTH  product low half / quotient
//   out_hi  out WIDTH  product high half / remainder
//   flags   out 4      {N, V, Z, C}
// Macro: CPU_MULDIV_DIV_EN enables the divide datapath. Without it, divide
// operations pass IDLE -> FIX -> DONE and report zero results with V set.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = CPU_WORD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       oper,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out_lo,
    output logic [WIDTH-1:0] out_hi,
    output logic [3:0]       flags
);

    localparam int CNT_W = md_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    StrcInMulDiv  ctrl_in;
    StrcOutMulDiv ctrl_out;

    MulDivState state_q, state_d;
    MulDivOper  op_q;

    logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
    logic             sign_a_q, sign_b_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] out_lo_q, out_hi_q;
    logic [3:0]       flags_q;

    logic             accept;
    logic             in_signed;
    logic             in_sign_a, in_sign_b;
    logic [WIDTH-1:0] step_hi, step_lo;

    logic [WIDTH-1:0] fix_lo, fix_hi;
    logic [3:0]       fix_flags;
    logic [2*WIDTH-1:0] prod_mag, prod_res;

    assign ctrl_in.start = start;
    assign ctrl_in.oper  = MulDivOper'(oper);
    assign ctrl_in.flush = flush;

    assign accept    = ctrl_in.start && !ctrl_in.flush &&
                       (state_q == MdIdle || state_q == MdDone);
    assign in_signed = (ctrl_in.oper == MulS) || (ctrl_in.oper == DivS);
    assign in_sign_a = in_signed && a[WIDTH-1];
    assign in_sign_b = in_signed && b[WIDTH-1];

`ifdef CPU_MULDIV_DIV_EN
    logic [WIDTH-1:0] a_q;
    logic             div_zero_q, div_ovf_q;
`endif

    mul_div_step #(.WIDTH(WIDTH)) u_step (
`ifdef CPU_MULDIV_DIV_EN
        .is_div  (op_q[1]),
`endif
        .hi      (hi_q),
        .lo      (lo_q),
        .opnd    (opnd_q),
        .hi_next (step_hi),
        .lo_next (step_lo)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= MdIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ctrl_in.flush) begin
            state_d = MdIdle;
        end else begin
            case (state_q)
                MdIdle, MdDone: begin
                    if (ctrl_in.start) begin
`ifdef CPU_MULDIV_DIV_EN
                        state_d = MdRun;
`else
                        state_d = ctrl_in.oper[1] ? MdFix : MdRun;
`endif
                    end else begin
                        state_d = MdIdle;
                    end
                end
                MdRun:   if (count_q == LAST_STEP) state_d = MdFix;
                MdFix:   state_d = MdDone;
                default: state_d = MdIdle;
            endcase
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= MulU;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            count_q  <= '0;
        end else if (accept) begin
            op_q     <= ctrl_in.oper;
            hi_q     <= '0;
            lo_q     <= in_sign_a ? (WIDTH'(0) - a) : a;
            opnd_q   <= in_sign_b ? (WIDTH'(0) - b) : b;
            sign_a_q <= in_sign_a;
            sign_b_q <= in_sign_b;
            count_q  <= '0;
        end else if (state_q == MdRun && !ctrl_in.flush) begin
            hi_q    <= step_hi;
            lo_q    <= step_lo;
            count_q <= count_q + CNT_W'(1);
        end
    end

`ifdef CPU_MULDIV_DIV_EN
    // Special-case inputs are captured raw; the magnitude in lo_q is
    // consumed by the iterations and cannot be used to rebuild a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            div_zero_q <= 1'b0;
            div_ovf_q  <= 1'b0;
        end else if (accept) begin
            a_q        <= a;
            div_zero_q <= (b == '0);
            div_ovf_q  <= (ctrl_in.oper == DivS) && (a == MOST_NEG) && (b == '1);
        end
    end
`endif

    // ----------------------------------------------------------- FIX stage
    always_comb begin
        fix_lo    = '0;
        fix_hi    = '0;
        fix_flags = '0;
        prod_mag  = {hi_q, lo_q};
        prod_res  = (sign_a_q ^ sign_b_q) ? ((2*WIDTH)'(0) - prod_mag) : prod_mag;
        if (!op_q[1]) begin
            fix_lo            = prod_res[WIDTH-1:0];
            fix_hi            = prod_res[2*WIDTH-1:WIDTH];
            fix_flags[FLAG_C] = (op_q == MulU) && (fix_hi != '0);
            fix_flags[FLAG_V] = (op_q == MulS) && (fix_hi != {WIDTH{fix_lo[WIDTH-1]}});
            fix_flags[FLAG_N] = fix_lo[WIDTH-1];
            fix_flags[FLAG_Z] = (fix_lo == '0);
        end else begin
`ifdef CPU_MULDIV_DIV_EN
            // Quotient sign follows the operand signs, remainder follows a.
            fix_lo = (sign_a_q ^ sign_b_q) ? (WIDTH'(0) - lo_q) : lo_q;
            fix_hi = sign_a_q ? (WIDTH'(0) - hi_q) : hi_q;
            if (div_zero_q) begin
                fix_lo            = '1;
                fix_hi            = a_q;
                fix_flags[FLAG_C] = 1'b1;
            end else if (div_ovf_q) begin
                fix_lo            = a_q;
                fix_hi            = '0;
                fix_flags[FLAG_V] = 1'b1;
            end
            fix_flags[FLAG_N] = fix_lo[WIDTH-1];
            fix_flags[FLAG_Z] = (fix_lo == '0);
`else
            fix_flags[FLAG_V] = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_lo_q <= '0;
            out_hi_q <= '0;
            flags_q  <= '0;
        end else if (state_q == MdFix && !ctrl_in.flush) begin
            out_lo_q <= fix_lo;
            out_hi_q <= fix_hi;
            flags_q  <= fix_flags;
        end
    end

    // ------------------------------------------------------------ outputs
    assign ctrl_out.busy  = (state_q == MdRun) || (state_q == MdFix);
    assign ctrl_out.done  = (state_q == MdDone);
    assign ctrl_out.flags = flags_q;

    assign busy   = ctrl_out.busy;
    assign done   = ctrl_out.done;
    assign flags  = ctrl_out.flags;
    assign out_lo = out_lo_q;
    assign out_hi = out_hi_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

    localparam int W = 32;
`ifdef CPU_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam logic [1:0] OP_MULU = 2'd0;
    localparam logic [1:0] OP_MULS = 2'd1;
    localparam logic [1:0] OP_DIVU = 2'd2;
    localparam logic [1:0] OP_DIVS = 2'd3;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic [3:0]   flags;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   oper = 2'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         flush = 1'b0;
    logic         busy, done;
    logic [W-1:0] out_lo, out_hi;
    logic [3:0]   flags;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    mul_div_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .oper   (oper),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .out_lo (out_lo),
        .out_hi (out_hi),
        .flags  (flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation's meaning.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t    e;
        longint  sx, sy, sp, sq, sr;
        logic [63:0] up;
        logic    nf, vf, zf, cf;
        e.cyc = 0;
        vf = 1'b0;
        cf = 1'b0;
        case (op)
            OP_MULU: begin
                up   = {32'd0, x} * {32'd0, y};
                e.lo = up[31:0];
                e.hi = up[63:32];
                cf   = (up > 64'h0000_0000_FFFF_FFFF);
            end
            OP_MULS: begin
                sx   = longint'($signed(x));
                sy   = longint'($signed(y));
                sp   = sx * sy;
                up   = sp;
                e.lo = up[31:0];
                e.hi = up[63:32];
                vf   = (sp < -64'sd2147483648) || (sp > 64'sd2147483647);
            end
            OP_DIVU: begin
                if (y == 0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = x; cf = 1'b1;
                end else begin
                    e.lo = x / y; e.hi = x % y;
                end
            end
            default: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                if (y == 0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = x; cf = 1'b1;
                end else if (sx == -64'sd2147483648 && sy == -64'sd1) begin
                    e.lo = x; e.hi = '0; vf = 1'b1;
                end else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    up = sq; e.lo = up[31:0];
                    up = sr; e.hi = up[31:0];
                end
            end
        endcase
        nf = e.lo[W-1];
        zf = (e.lo == 0);
        e.flags = {nf, vf, zf, cf};
        if (op[1] && !DIV_EN) begin
            e.lo = '0; e.hi = '0; e.flags = 4'b0100;
        end
        return e;
    endfunction

    function automatic int latency(input logic [1:0] op);
        return (op[1] && !DIV_EN) ? 2 : W + 2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one cycle; optionally enqueue the expected response.
    task automatic issue_exp(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                             input bit push, input exp_t e);
        exp_t ee;
        ee = e;
        start = 1'b1; oper = op; a = x; b = y;
        ee.cyc = cyc + latency(op);
        if (push) sb.push_back(ee);
        tick();
        start = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        issue_exp(op, x, y, 1'b1, model(op, x, y));
        repeat (latency(op)) tick();
    endtask

    task automatic run_const(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [W-1:0] lo, input logic [W-1:0] hi, input logic [3:0] f);
        exp_t e;
        e.lo = lo; e.hi = hi; e.flags = f; e.cyc = 0;
        if (op[1] && !DIV_EN) e = model(op, x, y);
        issue_exp(op, x, y, 1'b1, e);
        repeat (latency(op)) tick();
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("out_lo", 64'(out_lo), 64'(e.lo));
                chk("out_hi", 64'(out_hi), 64'(e.hi));
                chk("flags", 64'(flags), 64'(e.flags));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        logic [1:0] rop;
        logic [W-1:0] ra, rb, held_lo;
        exp_t e;

        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_out_lo", 64'(out_lo), 64'd0);
        chk("rst_out_hi", 64'(out_hi), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Directed cases with busy window check on the first one.
        t0 = cyc;
        issue_exp(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
                  '{lo: 32'h0000_0001, hi: 32'hFFFF_FFFE, flags: 4'b0001, cyc: 0});
        chk("busy_first", 64'(busy), 64'd1);
        repeat (W) tick();
        chk("busy_last", 64'(busy), 64'd1);
        chk("busy_last_cycle", 64'(cyc), 64'(t0 + W + 1));
        tick();
        chk("busy_off_in_done", 64'(busy), 64'd0);
        tick();

        run_const(OP_MULS, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 4'b1000);
        run_const(OP_DIVS, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b1000);
        run_const(OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 4'b0000);
        run_const(OP_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 4'b1001);
        run_const(OP_DIVS, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 4'b1100);

        // Flush at T+10: no done, outputs hold.
        held_lo = out_lo;
        t0 = cyc;
        issue_exp(OP_MULU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, model(OP_MULU, 32'h1234_5678, 32'h9ABC_DEF0));
        while (cyc < t0 + 10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_hold_lo", 64'(out_lo), 64'(held_lo));
        repeat (W + 4) tick();

        // Second op, with an ignored start pulse while busy.
        issue_exp(OP_MULU, 32'd6, 32'd7, 1'b1,
                  '{lo: 32'd42, hi: 32'd0, flags: 4'b0000, cyc: 0});
        repeat (3) tick();
        start = 1'b1; oper = OP_MULS; a = 32'd100; b = 32'd100;
        tick();
        start = 1'b0;
        chk("busy_ignore_start", 64'(busy), 64'd1);
        repeat (W) tick();

        // flush beats start.
        start = 1'b1; flush = 1'b1; oper = OP_MULU; a = 32'd3; b = 32'd3;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("flush_beats_start", 64'(busy), 64'd0);
        repeat (W + 4) tick();

        // Reset mid-operation.
        t0 = cyc;
        issue_exp(OP_MULU, 32'd9, 32'd9, 1'b1, model(OP_MULU, 32'd9, 32'd9));
        while (cyc < t0 + 5) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_out_lo", 64'(out_lo), 64'd0);
        chk("arst_out_hi", 64'(out_hi), 64'd0);
        chk("arst_flags", 64'(flags), 64'd0);
        sb.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (W + 6) tick();

        // Back-to-back: start held through busy; garbage operands ignored.
        t0 = cyc;
        e = model(OP_MULS, 32'h0001_0003, 32'hFFFF_0007);
        e.cyc = t0 + W + 2;
        sb.push_back(e);
        start = 1'b1; oper = OP_MULS; a = 32'h0001_0003; b = 32'hFFFF_0007;
        repeat (5) tick();
        oper = OP_MULU; a = 32'($urandom); b = 32'($urandom);
        while (cyc < t0 + W + 2) tick();
        ra = 32'($urandom); rb = 32'($urandom);
        e = model(OP_MULU, ra, rb);
        e.cyc = cyc + W + 2;
        sb.push_back(e);
        oper = OP_MULU; a = ra; b = rb;
        tick();
        start = 1'b0;
        repeat (W + 4) tick();

        // Randomized operations, sometimes chained from DONE.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pick();
            rb  = pick();
            issue_exp(rop, ra, rb, 1'b1, model(rop, ra, rb));
            repeat (latency(rop) - 1 + int'($urandom_range(0, 2))) tick();
        end
        repeat (W + 6) tick();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative, parametrised multiply/divide unit for the execute stage, alongside the combinational ALU. It adds what the single-cycle ALU lacks: full double-width products, signed/unsigned multiply, and signed/unsigned divide with remainder. One operation is in flight at a time, over a start/busy/done handshake, at one bit per cycle. Flag outputs use the same N/V/Z/C slot positions as the ALU, so the flags register update path is shared.

## Interface
- WIDTH, default `CPU_WORD_WIDTH` (32): operand width; must be ≥ 4 and a power of two.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE or DONE.
- oper  in  2  operation: MulU, MulS, DivU, DivS.
- a  in  WIDTH  multiplicand / dividend.
- b  in  WIDTH  multiplier / divisor.
- flush  in  1  abandon current operation.
- busy  out  1  high in RUN and FIX.
- done  out  1  one-cycle pulse, high in DONE.
- out_lo  out  WIDTH  product low half / quotient.
- out_hi  out  WIDTH  product high half / remainder.
- flags  out  4  N, V, Z, C in the shared flag slot positions.

## Operation
- States: IDLE, RUN, FIX, DONE.
  - IDLE/DONE → RUN on start & !flush: latch oper, operand magnitudes (signed opers), sign bits; clear count.
  - RUN: one shift-add (mul) or restoring shift-subtract (div) step per edge. After WIDTH steps → FIX.
  - FIX: apply sign correction and special cases, compute flags → DONE.
  - DONE → IDLE on the next edge unless start is high; start in DONE is accepted, so back-to-back operations are allowed.
- start while busy is ignored; it is neither queued nor an error.
- flush high on any edge → IDLE; no done pulse; outputs hold their previous values. flush beats start in the same cycle.
- Arithmetic:
  - Multiply: exact 2·WIDTH-bit product.
  - Divide: quotient truncates toward zero; remainder takes the dividend's sign.
- Division by zero: quotient all-ones, remainder = a, C=1.
- Signed overflow (most-negative / −1): quotient = a, remainder 0, V=1.
- Flags:
  - N = out_lo MSB; Z = (out_lo == 0).
  - Mul: C = (out_hi ≠ 0) for MulU; V = out_hi is not the sign-extension of out_lo for MulS; all other mul flags 0.
  - Div: C = divide-by-zero; V = signed overflow.
- out_lo, out_hi and flags change only on the FIX→DONE edge and are held until the next completion.

## Timing
- start high in cycle T → done high in cycle T+WIDTH+2 (34 cycles at WIDTH=32). Latency is fixed and independent of operand values.
- busy is high in cycles T+1 … T+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles when start is held in DONE.
- Reset values: state IDLE, busy 0, done 0, out_lo 0, out_hi 0, flags 0, count 0.
- Reset asserted mid-operation aborts immediately; there is no done pulse after release.

## Configuration
- `CPU_MULDIV_DIV_EN` defined: full behaviour as above.
- Undefined: divide datapath omitted.
  - DivU/DivS skip RUN: IDLE → FIX → DONE, so done is high at T+2.
  - Outputs: out_lo = 0, out_hi = 0, flags = V=1 only.
  - Multiply is unaffected.

## Structure
- pkg_cpu gains:
  - enum MulDivOper (MulU, MulS, DivU, DivS);
  - enum MulDivState;
  - structs StrcInMulDiv and StrcOutMulDiv, matching the ALU's struct-port style;
  - constant for the iteration count width, $clog2(WIDTH)+1.
- Sub-module mul_div_step: the combinational single-iteration datapath (add-or-pass for multiply, trial-subtract for divide). The parent holds the FSM, counter, operand registers and FIX logic.

## Test plan
All cases at WIDTH=32.
- MulU 0xFFFFFFFF × 0xFFFFFFFF → hi 0xFFFFFFFE, lo 0x00000001, C=1; done exactly at T+34.
- MulS −3 × 5 → hi 0xFFFFFFFF, lo 0xFFFFFFF1, N=1, V=0, C=0.
- DivS −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DivU 100 / 7 → 14, remainder 2.
- DivU 100 / 0 → quotient 0xFFFFFFFF, remainder 100, C=1. DivS 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, V=1.
- MulU started, flush at T+10, then MulU 6 × 7 → no done for the first operation; second gives lo 42, hi 0. A start pulse during busy is ignored.
- rst_n low at T+5 → outputs and flags go to 0 and busy drops asynchronously; no done after release. Back-to-back start held in DONE gives done pulses 34 cycles apart.
